md_scheduler: RTL

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler with architectural HI/LO registers and pipeline stall generation.
// Latency: mult MUL_CYC cycles, div DIV_CYC cycles, mthi/mtlo commit at the accepting edge.
// Backpressure: stall holds D while busy or while a mul/div issues and md_D is set; start is ignored while busy.
module md_scheduler #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        md_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic            wr_q, wr_d;
    logic            busy_q, busy_d;

    logic [63:0]     prod;
    logic [31:0]     a_mag, b_mag, divisor, uq, ur, quo, rem;
    logic            is_signed, a_neg, b_neg;

    // Operand arithmetic: signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        a_mag     = a_neg ? (~A + 32'd1) : A;
        b_mag     = b_neg ? (~B + 32'd1) : B;
        prod      = is_signed ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                              : ({32'd0, A} * {32'd0, B});
        // A zero divisor is replaced so the divider never sees it; the result is discarded anyway
        divisor   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq        = a_mag / divisor;
        ur        = a_mag % divisor;
        quo       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem       = a_neg ? (~ur + 32'd1) : ur;
    end

    // Next-state: accept in IDLE, count down while busy, commit the held result on the last busy cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        3'b000, 3'b001: begin
                            state_d  = MUL;
                            cnt_d    = CW'(MUL_CYC);
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            wr_d     = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_d  = DIV;
                            cnt_d    = CW'(DIV_CYC);
                            res_hi_d = rem;
                            res_lo_d = quo;
                            wr_d     = (B != 32'd0);
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register with synchronous reset that also drops any pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign stall = md_D & (busy_q | (start & ~op[2]));

endmodule
